// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and helpers for the raster timing generator.
// Default parameters of vga_timing_generator come from the 640x480@60 set.
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FRONT   = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BACK    = 33;
    localparam bit VGA640_HSYNC_POL = 1'b0;
    localparam bit VGA640_VSYNC_POL = 1'b0;

    // 800x600@60 runs from a 40 MHz pixel clock with positive sync pulses
    localparam int SVGA800_H_ACTIVE  = 800;
    localparam int SVGA800_H_FRONT   = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BACK    = 88;
    localparam int SVGA800_V_ACTIVE  = 600;
    localparam int SVGA800_V_FRONT   = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BACK    = 23;
    localparam bit SVGA800_HSYNC_POL = 1'b1;
    localparam bit SVGA800_VSYNC_POL = 1'b1;

    function automatic int calcTotal(input int active, input int front,
                                     input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, visible-area and sync decode.
// Decode applies to the position being presented this cycle (0 while cleared).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = 640,
    parameter int FRONT    = 16,
    parameter int SYNC     = 96,
    parameter int BACK     = 48,
    parameter bit POLARITY = 1'b0,
    parameter int WIDTH    = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_advance,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap,
    output logic             o_in_active,
    output logic             o_sync
);

    localparam int TOTAL = calcTotal(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [WIDTH-1:0] L_TOTAL_M1   = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] L_ACTIVE     = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] L_SYNC_START = WIDTH'(ACTIVE + FRONT);
    localparam logic [WIDTH-1:0] L_SYNC_END   = WIDTH'(ACTIVE + FRONT + SYNC);

    generate
        if (FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_zeroTiming
            $error("vga_axis_counter: porch and sync widths must be non-zero");
        end
        if ((longint'(1) << WIDTH) < longint'(TOTAL)) begin : g_narrowCount
            $error("vga_axis_counter: WIDTH too small for axis total");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_pos;
    logic [WIDTH-1:0] w_next;

    assign w_pos  = i_clear ? '0 : r_cnt;
    assign o_wrap = (w_pos == L_TOTAL_M1);
    assign w_next = o_wrap ? '0 : w_pos + 1'b1;

    // A clear together with an advance restarts from 0 and still steps past it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_advance) begin
            r_cnt <= w_next;
        end else if (i_clear) begin
            r_cnt <= '0;
        end
    end

    assign o_count     = w_pos;
    assign o_in_active = (w_pos < L_ACTIVE);
    assign o_sync      = ((w_pos >= L_SYNC_START) && (w_pos < L_SYNC_END)) ? POLARITY : ~POLARITY;

endmodule

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing generator with pixel clock-enable, resync
// and registered coordinate/sync/strobe outputs.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA640_H_ACTIVE,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_ACTIVE  = VGA640_V_ACTIVE,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter bit HSYNC_POL = VGA640_HSYNC_POL,
    parameter bit VSYNC_POL = VGA640_VSYNC_POL,
    parameter int COORD_W   = 11
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ce,
    input  logic               i_resync,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_active,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_line_start,
    output logic               o_frame_start
);

    logic [COORD_W-1:0] w_hCount;
    logic [COORD_W-1:0] w_vCount;
    logic               w_hWrap;
    logic               w_vWrapUnused;
    logic               w_hActive;
    logic               w_vActive;
    logic               w_hSync;
    logic               w_vSync;
    logic               w_vAdvance;

    // The vertical axis steps once per completed line
    assign w_vAdvance = i_ce & w_hWrap;

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .POLARITY (HSYNC_POL),
        .WIDTH    (COORD_W)
    ) u_hAxis (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_advance   (i_ce),
        .i_clear     (i_resync),
        .o_count     (w_hCount),
        .o_wrap      (w_hWrap),
        .o_in_active (w_hActive),
        .o_sync      (w_hSync)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .POLARITY (VSYNC_POL),
        .WIDTH    (COORD_W)
    ) u_vAxis (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_advance   (w_vAdvance),
        .i_clear     (i_resync),
        .o_count     (w_vCount),
        .o_wrap      (w_vWrapUnused),
        .o_in_active (w_vActive),
        .o_sync      (w_vSync)
    );

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_lineStart;
    logic               r_frameStart;

    // Every output is captured on the same enabled edge so they describe one pixel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_active     <= 1'b0;
            r_hsync      <= ~HSYNC_POL;
            r_vsync      <= ~VSYNC_POL;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else if (i_ce) begin
            r_x          <= w_hCount;
            r_y          <= w_vCount;
            r_active     <= w_hActive & w_vActive;
            r_hsync      <= w_hSync;
            r_vsync      <= w_vSync;
            r_lineStart  <= (w_hCount == '0);
            r_frameStart <= (w_hCount == '0) && (w_vCount == '0);
        end else begin
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_active      = r_active;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_line_start  = r_lineStart;
    assign o_frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480, 800x600 and a tiny 15x11 raster share stimulus,
// each checked against a behavioural raster model every cycle.
module tb_vga_timing_generator;

    logic clk;
    logic rst_n;
    logic ce;
    logic resync;

    logic [10:0] x0, y0, x1, y1;
    logic [3:0]  x2, y2;
    logic act0, hs0, vs0, ls0, fs0;
    logic act1, hs1, vs1, ls1, fs1;
    logic act2, hs2, vs2, ls2, fs2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model configuration: index 0 = 640x480, 1 = 800x600, 2 = tiny
    int hAct[3] = '{640, 800, 8};
    int hFr[3]  = '{16, 40, 2};
    int hSy[3]  = '{96, 128, 3};
    int hBk[3]  = '{48, 88, 2};
    int vAct[3] = '{480, 600, 6};
    int vFr[3]  = '{10, 1, 1};
    int vSy[3]  = '{2, 4, 2};
    int vBk[3]  = '{33, 23, 2};
    bit hPol[3] = '{1'b0, 1'b1, 1'b1};
    bit vPol[3] = '{1'b0, 1'b1, 1'b0};

    int cx[3], cy[3], ox[3], oy[3];
    bit started[3], mLs[3], mFs[3];

    vga_timing_generator u_dut640 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_resync(resync),
        .o_x(x0), .o_y(y0), .o_active(act0), .o_hsync(hs0), .o_vsync(vs0),
        .o_line_start(ls0), .o_frame_start(fs0)
    );

    vga_timing_generator #(
        .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_ACTIVE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(11)
    ) u_dut800 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_resync(resync),
        .o_x(x1), .o_y(y1), .o_active(act1), .o_hsync(hs1), .o_vsync(vs1),
        .o_line_start(ls1), .o_frame_start(fs1)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .COORD_W(4)
    ) u_dutTiny (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_resync(resync),
        .o_x(x2), .o_y(y2), .o_active(act2), .o_hsync(hs2), .o_vsync(vs2),
        .o_line_start(ls2), .o_frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset values of the raster model
    task automatic resetModel();
        for (int d = 0; d < 3; d++) begin
            cx[d] = 0; cy[d] = 0; ox[d] = 0; oy[d] = 0;
            started[d] = 1'b0; mLs[d] = 1'b0; mFs[d] = 1'b0;
        end
    endtask

    // One clock of the raster model for the given inputs
    task automatic modelStep(input bit c, input bit r);
        int px, py;
        for (int d = 0; d < 3; d++) begin
            if (c) begin
                px = r ? 0 : cx[d];
                py = r ? 0 : cy[d];
                ox[d] = px; oy[d] = py; started[d] = 1'b1;
                mLs[d] = (px == 0);
                mFs[d] = (px == 0) && (py == 0);
                px = px + 1;
                if (px == hAct[d] + hFr[d] + hSy[d] + hBk[d]) begin
                    px = 0;
                    py = py + 1;
                    if (py == vAct[d] + vFr[d] + vSy[d] + vBk[d]) py = 0;
                end
                cx[d] = px; cy[d] = py;
            end else begin
                mLs[d] = 1'b0; mFs[d] = 1'b0;
                if (r) begin cx[d] = 0; cy[d] = 0; end
            end
        end
    endtask

    // Drive inputs, take one clock edge, and sample 1 ns after it
    task automatic applyStimulus(input bit c, input bit r);
        ce = c;
        resync = r;
        @(posedge clk);
        if (rst_n) modelStep(c, r);
        #1;
        cyc++;
    endtask

    task automatic check1(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d required %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkOutput(input int d, input logic [10:0] ax, input logic [10:0] ay,
                               input logic aAct, input logic aHs, input logic aVs,
                               input logic aLs, input logic aFs);
        logic eAct, eHs, eVs;
        eAct = started[d] && (ox[d] < hAct[d]) && (oy[d] < vAct[d]);
        eHs  = ((ox[d] >= hAct[d] + hFr[d]) && (ox[d] < hAct[d] + hFr[d] + hSy[d])) ? hPol[d] : !hPol[d];
        eVs  = ((oy[d] >= vAct[d] + vFr[d]) && (oy[d] < vAct[d] + vFr[d] + vSy[d])) ? vPol[d] : !vPol[d];
        check1($sformatf("dut%0d x", d), ax, 11'(ox[d]));
        check1($sformatf("dut%0d y", d), ay, 11'(oy[d]));
        check1($sformatf("dut%0d active", d), {10'd0, aAct}, {10'd0, eAct});
        check1($sformatf("dut%0d hsync", d), {10'd0, aHs}, {10'd0, eHs});
        check1($sformatf("dut%0d vsync", d), {10'd0, aVs}, {10'd0, eVs});
        check1($sformatf("dut%0d line_start", d), {10'd0, aLs}, {10'd0, mLs[d]});
        check1($sformatf("dut%0d frame_start", d), {10'd0, aFs}, {10'd0, mFs[d]});
    endtask

    task automatic checkAll();
        checkOutput(0, x0, y0, act0, hs0, vs0, ls0, fs0);
        checkOutput(1, x1, y1, act1, hs1, vs1, ls1, fs1);
        checkOutput(2, {7'd0, x2}, {7'd0, y2}, act2, hs2, vs2, ls2, fs2);
    endtask

    initial begin
        int lastLs0, lastFs2, low0, firstLow0, high1, firstHigh1, vlow2;
        logic [10:0] heldX;

        rst_n = 1'b0;
        ce = 1'b0;
        resync = 1'b0;
        resetModel();
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkAll();
        check1("reset hsync 640", {10'd0, hs0}, 11'd1);
        check1("reset hsync 800", {10'd0, hs1}, 11'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0);
            checkAll();
        end
        check1("idle x", x0, 11'd0);
        check1("idle active", {10'd0, act0}, 11'd0);

        applyStimulus(1, 0);
        checkAll();
        check1("first x", x0, 11'd0);
        check1("first y", y0, 11'd0);
        check1("first active", {10'd0, act0}, 11'd1);
        check1("first frame_start", {10'd0, fs0}, 11'd1);
        check1("first line_start", {10'd0, ls0}, 11'd1);

        lastLs0 = cyc; lastFs2 = cyc;
        low0 = 0; firstLow0 = -1; high1 = 0; firstHigh1 = -1; vlow2 = (vs2 == 1'b0) ? 1 : 0;
        for (int i = 1; i < 1200; i++) begin
            applyStimulus(1, 0);
            checkAll();
            if (i < 800 && hs0 == 1'b0) begin
                low0++;
                if (firstLow0 < 0) firstLow0 = int'(x0);
            end
            if (i < 1056 && hs1 == 1'b1) begin
                high1++;
                if (firstHigh1 < 0) firstHigh1 = int'(x1);
            end
            if (i < 165 && vs2 == 1'b0) vlow2++;
            if (ls0 == 1'b1) begin
                check1("line period 640", 11'(cyc - lastLs0), 11'd800);
                lastLs0 = cyc;
            end
            if (fs2 == 1'b1) begin
                check1("frame period tiny", 11'(cyc - lastFs2), 11'd165);
                lastFs2 = cyc;
            end
        end
        check1("hsync low width 640", 11'(low0), 11'd96);
        check1("hsync first low x 640", 11'(firstLow0), 11'd656);
        check1("hsync high width 800", 11'(high1), 11'd128);
        check1("hsync first high x 800", 11'(firstHigh1), 11'd840);
        check1("vsync low clocks tiny", 11'(vlow2), 11'd30);

        for (int i = 0; i < 20; i++) begin
            applyStimulus((i % 2) == 0, 0);
            checkAll();
        end

        for (int i = 0; i < 900 && ox[0] != 299; i++) begin
            applyStimulus(1, 0);
            checkAll();
        end
        check1("reach x 299", x0, 11'd299);
        applyStimulus(1, 1);
        checkAll();
        check1("resync ce x", x0, 11'd0);
        check1("resync ce y", y0, 11'd0);
        check1("resync ce line_start", {10'd0, ls0}, 11'd1);
        check1("resync ce frame_start", {10'd0, fs0}, 11'd1);
        applyStimulus(1, 0);
        checkAll();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0);
            checkAll();
        end
        heldX = x0;
        applyStimulus(0, 1);
        checkAll();
        check1("resync idle hold x", x0, heldX);
        applyStimulus(0, 0);
        checkAll();
        applyStimulus(1, 0);
        checkAll();
        check1("resync idle then x", x0, 11'd0);
        check1("resync idle then frame_start", {10'd0, fs0}, 11'd1);

        for (int i = 0; i < 200 && !(oy[2] == 7 && ox[2] == 5); i++) begin
            applyStimulus(1, 0);
            checkAll();
        end
        check1("reach tiny vsync row", {7'd0, y2}, 11'd7);
        check1("tiny vsync asserted", {10'd0, vs2}, 11'd0);
        #3;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkAll();
        check1("async reset tiny vsync", {10'd0, vs2}, 11'd1);
        check1("async reset tiny y", {7'd0, y2}, 11'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0);
        checkAll();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0);
            checkAll();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
